adc_burst_arbiter: RTL and testbench

Drains two ADC sample FIFOs (first-word-fall-through, pop on read-enable) into one shared output word stream, framing each burst as a header word followed by sample words. It sits between the per-channel ADC capture FIFOs and the packet/transport logic. It arbitrates round-robin between channels, supports a flush mode for partial bursts, and latches per-channel overflow.

---
 rtl/adc_burst_arbiter_if.sv | 46 ++++
 rtl/adc_burst_arbiter.sv | 147 ++++++++++++++
 tb/tb_adc_burst_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_burst_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adc_burst_arbiter_if : FIFO-side, stream-side and status signals of the
//                        two-channel ADC burst arbiter.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface adc_burst_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LVL_WIDTH  = 10
);
  logic                  enable;
  logic                  flush;
  logic                  ovf_clr;
  logic [DATA_WIDTH-1:0] ch0_q;
  logic [DATA_WIDTH-1:0] ch1_q;
  logic                  ch0_empty;
  logic                  ch1_empty;
  logic                  ch0_full;
  logic                  ch1_full;
  logic [LVL_WIDTH-1:0]  ch0_level;
  logic [LVL_WIDTH-1:0]  ch1_level;
  logic                  ch0_re;
  logic                  ch1_re;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic                  busy;
  logic [1:0]            ovf;

  // Arbiter view: owns the stream, the FIFO pops and the status outputs.
  modport master (
    input  enable, flush, ovf_clr,
    input  ch0_q, ch1_q, ch0_empty, ch1_empty, ch0_full, ch1_full,
    input  ch0_level, ch1_level, out_ready,
    output ch0_re, ch1_re, out_data, out_valid, out_last, busy, ovf
  );

  modport slave (
    output enable, flush, ovf_clr,
    output ch0_q, ch1_q, ch0_empty, ch1_empty, ch0_full, ch1_full,
    output ch0_level, ch1_level, out_ready,
    input  ch0_re, ch1_re, out_data, out_valid, out_last, busy, ovf
  );
endinterface
`default_nettype wire

// File: rtl/adc_burst_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adc_burst_arbiter : round-robin drain of two FWFT ADC FIFOs into one framed
//                     word stream (header + samples), with flush and overflow.
// Revision: 1.0
// ---------------------------------------------------------------------------
module adc_burst_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int LVL_WIDTH  = 10,
  parameter int BURST_LEN  = 32
) (
  input wire clk,
  input wire reset,
  adc_burst_arbiter_if.master bus
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_HDR  = 2'd1;
  localparam logic [1:0] c_DATA = 2'd2;

  localparam logic [LVL_WIDTH-1:0] c_BURST_LVL  = LVL_WIDTH'(BURST_LEN);
  localparam logic [7:0]           c_BURST_LEN8 = 8'(BURST_LEN);

  logic [1:0]      state_q, state_d;
  logic            sel_q, sel_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [1:0][5:0] seq_q, seq_d;
  logic            ptr_q, ptr_d;
  logic [1:0]      ovf_q, ovf_d;

  logic [LVL_WIDTH-1:0] w_level [2];
  logic [7:0]           w_len   [2];
  logic [1:0]           w_empty;
  logic [1:0]           w_at_burst;
  logic [1:0]           w_elig;
  logic                 w_grant;

  logic [DATA_WIDTH-1:0] w_out_data;
  logic                  w_out_valid;
  logic                  w_out_last;
  logic                  w_re0;
  logic                  w_re1;

  assign w_level[0] = bus.ch0_level;
  assign w_level[1] = bus.ch1_level;
  assign w_empty    = {bus.ch1_empty, bus.ch0_empty};

  // len never exceeds level, so a granted burst can never underflow its FIFO.
  for (genvar c = 0; c < 2; c++) begin : g_ch
    assign w_at_burst[c] = (w_level[c] >= c_BURST_LVL);
    assign w_elig[c]     = bus.enable && (w_at_burst[c] || (bus.flush && !w_empty[c]));
    assign w_len[c]      = w_at_burst[c] ? c_BURST_LEN8 : w_level[c][7:0];
  end

  // On contention the channel that was not granted last wins.
  assign w_grant = (&w_elig) ? ~ptr_q : w_elig[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= c_IDLE;
      sel_q   <= 1'b0;
      len_q   <= 8'd0;
      cnt_q   <= 8'd0;
      seq_q   <= '0;
      ptr_q   <= 1'b1;
      ovf_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      seq_q   <= seq_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    seq_d   = seq_q;
    ptr_d   = ptr_q;
    // A set in the same cycle as a clear wins.
    ovf_d   = (ovf_q & ~{2{bus.ovf_clr}}) | {bus.ch1_full, bus.ch0_full};
    case (state_q)
      c_IDLE: begin
        if (|w_elig) begin
          sel_d   = w_grant;
          len_d   = w_len[w_grant];
          state_d = c_HDR;
        end
      end
      c_HDR: begin
        if (bus.out_ready) begin
          cnt_d   = len_q;
          state_d = c_DATA;
        end
      end
      c_DATA: begin
        if (bus.out_ready) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            seq_d[sel_q] = seq_q[sel_q] + 6'd1;
            ptr_d        = sel_q;
            state_d      = c_IDLE;
          end
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    w_out_data  = '0;
    w_out_valid = 1'b0;
    w_out_last  = 1'b0;
    w_re0       = 1'b0;
    w_re1       = 1'b0;
    case (state_q)
      c_HDR: begin
        w_out_valid = 1'b1;
        w_out_data  = {1'b1, sel_q, seq_q[sel_q], len_q};
      end
      c_DATA: begin
        w_out_valid = 1'b1;
        w_out_data  = sel_q ? bus.ch1_q : bus.ch0_q;
        w_out_last  = (cnt_q == 8'd1);
        w_re0       = !sel_q && bus.out_ready;
        w_re1       = sel_q && bus.out_ready;
      end
      default: ;
    endcase
  end

  assign bus.out_data  = w_out_data;
  assign bus.out_valid = w_out_valid;
  assign bus.out_last  = w_out_last;
  assign bus.ch0_re    = w_re0;
  assign bus.ch1_re    = w_re1;
  assign bus.busy      = (state_q != c_IDLE);
  assign bus.ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_burst_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_adc_burst_arbiter : packet-level reference model of the burst arbiter,
//                        driven with directed and random stimulus.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_adc_burst_arbiter;
  localparam int BL = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  adc_burst_arbiter_if #(.DATA_WIDTH(16), .LVL_WIDTH(10)) bus ();

  adc_burst_arbiter #(
    .DATA_WIDTH(16),
    .LVL_WIDTH (10),
    .BURST_LEN (BL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Model: FIFO contents, plus the remaining words of the packet in flight.
  logic [15:0] fifo0[$];
  logic [15:0] fifo1[$];
  logic [15:0] pkt[$];
  logic [15:0] hdr_log[$];
  int          m_len;
  bit          m_sel;
  int          m_seq[2];
  bit          m_ptr;
  logic [1:0]  m_ovf;

  int n_assert = 0;
  int n_fail   = 0;
  int re0_cnt  = 0;
  int re1_cnt  = 0;
  int last_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pkt.delete();
    m_len = 0;
    m_sel = 1'b0;
    m_seq[0] = 0;
    m_seq[1] = 0;
    m_ptr = 1'b1;
    m_ovf = 2'b00;
  endtask

  task automatic drive_fifo();
    bus.ch0_empty = (fifo0.size() == 0);
    bus.ch1_empty = (fifo1.size() == 0);
    bus.ch0_q     = (fifo0.size() > 0) ? fifo0[0] : 16'h0000;
    bus.ch1_q     = (fifo1.size() > 0) ? fifo1[0] : 16'h0000;
    bus.ch0_level = 10'(fifo0.size());
    bus.ch1_level = 10'(fifo1.size());
  endtask

  task automatic check_outputs();
    bit ev, dp;
    ev = (pkt.size() > 0);
    dp = ev && (pkt.size() <= m_len);
    chk("out_valid", bus.out_valid, ev);
    chk("out_data", bus.out_data, ev ? pkt[0] : 16'h0000);
    chk("out_last", bus.out_last, dp && pkt.size() == 1);
    chk("ch0_re", bus.ch0_re, dp && !m_sel && bus.out_ready);
    chk("ch1_re", bus.ch1_re, dp && m_sel && bus.out_ready);
    chk("busy", bus.busy, ev);
    chk("ovf", bus.ovf, m_ovf);
    if (ev && !dp && bus.out_ready) hdr_log.push_back(bus.out_data);
    re0_cnt  += int'(bus.ch0_re);
    re1_cnt  += int'(bus.ch1_re);
    last_cnt += int'(bus.out_last && bus.out_ready);
  endtask

  task automatic update_model();
    bit e0, e1;
    int sz;
    if (reset) begin
      model_reset();
      return;
    end
    m_ovf = (m_ovf & ~{2{bus.ovf_clr}}) | {bus.ch1_full, bus.ch0_full};
    if (pkt.size() > 0) begin
      if (bus.out_ready) begin
        if (pkt.size() <= m_len) begin
          if (m_sel) void'(fifo1.pop_front());
          else       void'(fifo0.pop_front());
          if (pkt.size() == 1) begin
            m_seq[m_sel] = (m_seq[m_sel] + 1) % 64;
            m_ptr = m_sel;
          end
        end
        void'(pkt.pop_front());
      end
    end else begin
      e0 = bus.enable && (fifo0.size() >= BL || (bus.flush && fifo0.size() > 0));
      e1 = bus.enable && (fifo1.size() >= BL || (bus.flush && fifo1.size() > 0));
      if (e0 || e1) begin
        m_sel = (e0 && e1) ? !m_ptr : e1;
        sz    = m_sel ? fifo1.size() : fifo0.size();
        m_len = (sz < BL) ? sz : BL;
        pkt.push_back({1'b1, m_sel, 6'(m_seq[m_sel]), 8'(m_len)});
        for (int i = 0; i < m_len; i++) pkt.push_back(m_sel ? fifo1[i] : fifo0[i]);
      end
    end
  endtask

  task automatic step();
    drive_fifo();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic push(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      if (ch == 0) fifo0.push_back(16'($urandom));
      else         fifo1.push_back(16'($urandom));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    hdr_log.delete();
    re0_cnt  = 0;
    re1_cnt  = 0;
    last_cnt = 0;
  endtask

  initial begin
    int r0;
    reset         = 1'b1;
    bus.enable    = 1'b0;
    bus.flush     = 1'b0;
    bus.ovf_clr   = 1'b0;
    bus.ch0_full  = 1'b0;
    bus.ch1_full  = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    do_reset();

    // Normal burst on ch0, then a second one to expose seq0 = 1.
    bus.enable    = 1'b1;
    bus.out_ready = 1'b1;
    push(0, 4);
    run(8);
    chk("t1_hdr", hdr_log.size() > 0 ? hdr_log[0] : 16'hxxxx, 16'h8004);
    chk("t1_re0_pulses", re0_cnt, 4);
    chk("t1_re1_pulses", re1_cnt, 0);
    chk("t1_last_pulses", last_cnt, 1);
    push(0, 4);
    run(8);
    chk("t1_seq0_hdr", hdr_log.size() > 1 ? hdr_log[1] : 16'hxxxx, 16'h8104);

    // Round robin from reset with both channels loaded.
    do_reset();
    bus.enable = 1'b1;
    push(0, 12);
    push(1, 12);
    run(40);
    chk("rr_hdr0", hdr_log.size() > 2 ? hdr_log[0] : 16'hxxxx, 16'h8004);
    chk("rr_hdr1", hdr_log.size() > 2 ? hdr_log[1] : 16'hxxxx, 16'hC004);
    chk("rr_hdr2", hdr_log.size() > 2 ? hdr_log[2] : 16'hxxxx, 16'h8104);
    chk("rr_drained", fifo0.size() + fifo1.size(), 0);

    // Partial data: nothing without flush, one short burst with it.
    do_reset();
    bus.enable = 1'b1;
    push(1, 2);
    run(6);
    chk("fl_no_burst", hdr_log.size(), 0);
    bus.flush = 1'b1;
    run(6);
    bus.flush = 1'b0;
    chk("fl_hdr", hdr_log.size() > 0 ? hdr_log[0] : 16'hxxxx, 16'hC002);
    chk("fl_re1_pulses", re1_cnt, 2);
    chk("fl_idle", bus.busy, 1'b0);

    // Backpressure pattern 1,0,0,1 repeating.
    do_reset();
    bus.enable = 1'b1;
    push(0, 4);
    for (int i = 0; i < 30; i++) begin
      bus.out_ready = (i % 4 == 0) || (i % 4 == 3);
      step();
    end
    chk("bp_re0_pulses", re0_cnt, 4);
    chk("bp_last_pulses", last_cnt, 1);
    bus.out_ready = 1'b1;

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bus.out_ready = ($urandom % 4) != 0;
      bus.enable    = ($urandom % 8) != 0;
      bus.flush     = ($urandom % 4) == 0;
      bus.ovf_clr   = ($urandom % 16) == 0;
      bus.ch0_full  = ($urandom % 32) == 0;
      bus.ch1_full  = ($urandom % 32) == 0;
      if (fifo0.size() < 20 && ($urandom % 3) == 0) push(0, int'($urandom_range(1, 3)));
      if (fifo1.size() < 20 && ($urandom % 3) == 0) push(1, int'($urandom_range(1, 3)));
      step();
    end
    bus.flush    = 1'b0;
    bus.ovf_clr  = 1'b0;
    bus.ch0_full = 1'b0;
    bus.ch1_full = 1'b0;
    fifo0.delete();
    fifo1.delete();

    // Sequence wrap: 65 back-to-back ch0 bursts.
    do_reset();
    bus.enable    = 1'b1;
    bus.out_ready = 1'b1;
    push(0, 65 * BL);
    run(65 * (BL + 2) + 10);
    chk("wrap_hdr_count", hdr_log.size(), 65);
    chk("wrap_hdr63", hdr_log.size() > 64 ? hdr_log[63] : 16'hxxxx, 16'hBF04);
    chk("wrap_hdr64", hdr_log.size() > 64 ? hdr_log[64] : 16'hxxxx, 16'h8004);

    // Reset in the middle of a data phase.
    do_reset();
    bus.enable = 1'b1;
    push(0, 4);
    r0 = 0;
    while (r0 < 20 && !(pkt.size() > 0 && pkt.size() < m_len)) begin
      step();
      r0++;
    end
    chk("mid_data_reached", r0 < 20, 1'b1);
    bus.enable = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    fifo0.delete();
    step();
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);

    // Overflow capture, hold, set-wins-over-clear, then clear.
    bus.ch0_full = 1'b1;
    step();
    bus.ch0_full = 1'b0;
    run(4);
    chk("ovf_hold", bus.ovf, 2'b01);
    bus.ovf_clr  = 1'b1;
    bus.ch0_full = 1'b1;
    step();
    bus.ch0_full = 1'b0;
    step();
    bus.ovf_clr = 1'b0;
    chk("ovf_cleared", bus.ovf, 2'b00);
    run(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
